// File: rtl/sevenseg_scan_decoder.sv
// Receive-side monitor for an 8-digit multiplexed 7-segment bus: synchronizes the scan, waits for each
// digit to settle, decodes its segment pattern to a hex nibble and publishes a complete 32-bit frame.
module sevenseg_scan_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        DP,
  output logic [31:0] value,
  output logic [7:0]  dp_mask,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  logic [SYNC_STAGES-1:0][15:0] sync_q, sync_d;
  logic [7:0]       a_s;
  logic [6:0]       c_s;
  logic             dp_s;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mask_q, mask_d;
  logic [31:0]      slot_nib_q, slot_nib_d;
  logic [7:0]       slot_dp_q, slot_dp_d;
  logic [7:0]       slot_blank_q, slot_blank_d;
  logic [7:0]       slot_err_q, slot_err_d;
  logic [31:0]      value_q, value_d;
  logic [7:0]       dp_mask_q, dp_mask_d;
  logic [7:0]       blank_mask_q, blank_mask_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [2:0]       a_idx;
  logic             a_onehot;
  logic             a_same;
  logic             capture;
  logic             dispatch;
  logic             frame_done;
  logic [3:0]       dec_nib;
  logic             dec_blank;
  logic             dec_err;

  // Anode, cathode and DP share one synchronizer chain so a digit's pattern stays aligned with its enable
  always_comb begin
    sync_d[0] = {DP, cathode, anode};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign a_s  = sync_q[SYNC_STAGES-1][7:0];
  assign c_s  = sync_q[SYNC_STAGES-1][14:8];
  assign dp_s = sync_q[SYNC_STAGES-1][15];

  always_comb begin
    a_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!a_s[i]) a_idx = 3'(i);
    end
  end

  assign a_onehot   = $onehot(~a_s);
  assign a_same     = (a_s == ~(8'd1 << idx_q));
  assign frame_done = (mask_q == 8'hFF);

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (c_s)
      7'h40:   dec_nib = 4'h0;
      7'h79:   dec_nib = 4'h1;
      7'h24:   dec_nib = 4'h2;
      7'h30:   dec_nib = 4'h3;
      7'h19:   dec_nib = 4'h4;
      7'h12:   dec_nib = 4'h5;
      7'h02:   dec_nib = 4'h6;
      7'h78:   dec_nib = 4'h7;
      7'h00:   dec_nib = 4'h8;
      7'h10:   dec_nib = 4'h9;
      7'h08:   dec_nib = 4'hA;
      7'h03:   dec_nib = 4'hB;
      7'h46:   dec_nib = 4'hC;
      7'h21:   dec_nib = 4'hD;
      7'h06:   dec_nib = 4'hE;
      7'h0E:   dec_nib = 4'hF;
      7'h7F:   dec_blank = 1'b1;
      default: dec_err = 1'b0 | 1'b1;
    endcase
  end

  // Any change of the selected anode re-dispatches: a new single-low digit restarts settling, anything else idles
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    dispatch = 1'b0;
    case (state_q)
      S_IDLE: dispatch = 1'b1;
      S_SETTLE: begin
        if (!a_same) begin
          dispatch = 1'b1;
        end else if (cnt_q == SETTLE_CNT) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: dispatch = !a_same;
      default: state_d = S_IDLE;
    endcase
    if (dispatch) begin
      if (a_onehot) begin
        state_d = S_SETTLE;
        idx_d   = a_idx;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // The cycle after the mask fills, publish the shadow slots and start the next frame from an empty mask
  always_comb begin
    mask_d       = frame_done ? 8'h00 : mask_q;
    slot_err_d   = frame_done ? 8'h00 : slot_err_q;
    slot_nib_d   = slot_nib_q;
    slot_dp_d    = slot_dp_q;
    slot_blank_d = slot_blank_q;
    if (capture) begin
      mask_d[idx_q]                   = 1'b1;
      slot_nib_d[{idx_q, 2'b00} +: 4] = dec_nib;
      slot_dp_d[idx_q]                = ~dp_s;
      slot_blank_d[idx_q]             = dec_blank;
      slot_err_d[idx_q]               = dec_err;
    end
    value_d       = frame_done ? slot_nib_q   : value_q;
    dp_mask_d     = frame_done ? slot_dp_q    : dp_mask_q;
    blank_mask_d  = frame_done ? slot_blank_q : blank_mask_q;
    frame_err_d   = frame_done ? |slot_err_q  : frame_err_q;
    frame_valid_d = frame_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '1;
      state_q       <= S_IDLE;
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      mask_q        <= 8'h00;
      slot_nib_q    <= 32'h0;
      slot_dp_q     <= 8'h00;
      slot_blank_q  <= 8'h00;
      slot_err_q    <= 8'h00;
      value_q       <= 32'h0;
      dp_mask_q     <= 8'h00;
      blank_mask_q  <= 8'h00;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      slot_nib_q    <= slot_nib_d;
      slot_dp_q     <= slot_dp_d;
      slot_blank_q  <= slot_blank_d;
      slot_err_q    <= slot_err_d;
      value_q       <= value_d;
      dp_mask_q     <= dp_mask_d;
      blank_mask_q  <= blank_mask_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign value       = value_q;
  assign dp_mask     = dp_mask_q;
  assign blank_mask  = blank_mask_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: drives scan segments and predicts frames with a
// segment-level model (a single-low anode held at least SETTLE+1 cycles captures that digit).
module tb_sevenseg_scan_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int SETTLE      = 4;
  localparam int CAP_MIN     = SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  anode = 8'hFF;
  logic [6:0]  cathode = 7'h7F;
  logic        DP = 1'b1;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic        frame_valid;
  logic        frame_err;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0]  m_nib [8];
  logic [7:0]  m_dp, m_blank, m_err, m_mask;
  logic [48:0] exp_q [$];
  logic [48:0] obs_q [$];

  sevenseg_scan_decoder #(.SYNC_STAGES(SYNC_STAGES), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode), .DP(DP),
    .value(value), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && frame_valid) obs_q.push_back({value, dp_mask, blank_mask, frame_err});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_capture(input int d, input logic [6:0] c, input logic dp_n);
    logic [31:0] w;
    bit hit = 0;
    m_nib[d] = 4'h0; m_blank[d] = 1'b0; m_err[d] = 1'b0;
    if (c == 7'h7F) m_blank[d] = 1'b1;
    else begin
      for (int k = 0; k < 16; k++) if (seg_tab[k] == c) begin m_nib[d] = 4'(k); hit = 1; end
      if (!hit) m_err[d] = 1'b1;
    end
    m_dp[d] = ~dp_n;
    m_mask[d] = 1'b1;
    if (&m_mask) begin
      for (int j = 0; j < 8; j++) w[4*j +: 4] = m_nib[j];
      exp_q.push_back({w, m_dp, m_blank, |m_err});
      m_mask = 8'h00;
      m_err = 8'h00;
    end
  endtask

  task automatic drive_seg(input logic [7:0] an, input logic [6:0] c, input logic dp_n, input int n);
    anode = an; cathode = c; DP = dp_n;
    repeat (n) @(posedge clk);
    #1;
    if ($countones(~an) == 1 && n >= CAP_MIN) begin
      for (int d = 0; d < 8; d++) if (!an[d]) model_capture(d, c, dp_n);
    end
  endtask

  task automatic idle(input int n);
    drive_seg(8'hFF, 7'h7F, 1'b1, n);
  endtask

  task automatic scan_word(input logic [31:0] w, input int dwell, input int gap);
    for (int d = 0; d < 8; d++) begin
      drive_seg(~(8'd1 << d), seg_tab[w[4*d +: 4]], 1'b1, dwell);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic pulse_reset();
    anode = 8'hFF; cathode = 7'h7F; DP = 1'b1;
    rst = 1'b1;
    m_mask = 8'h00; m_err = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (value !== 32'h0) begin n_err++; $display("[TB] FAIL reset_value: got %h expected 0", value); end
    n_vec++; if (dp_mask !== 8'h0) begin n_err++; $display("[TB] FAIL reset_dp: got %h expected 0", dp_mask); end
    n_vec++; if (blank_mask !== 8'h0) begin n_err++; $display("[TB] FAIL reset_blank: got %h expected 0", blank_mask); end
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b expected 0", frame_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_err: got %b expected 0", frame_err); end
    m_mask = 8'h00; m_err = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
  endtask

  task automatic test_basic_scan();
    scan_word(32'h12345678, 16, 2);
    scan_word(32'h12345678, 16, 2);
    idle(12);
    n_vec++; if (obs_q.size() !== 2) begin n_err++; $display("[TB] FAIL basic_pulses: got %0d expected 2", obs_q.size()); end
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL basic_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if ({value, dp_mask, blank_mask, frame_err} !== {32'h12345678, 8'h00, 8'h00, 1'b0})
      begin n_err++; $display("[TB] FAIL basic_outputs: got %h/%h/%h/%b expected 12345678/00/00/0", value, dp_mask, blank_mask, frame_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_dwell();
    logic [31:0] w = 32'h13579BDF;
    for (int d = 0; d < 8; d++) begin
      drive_seg(~(8'd1 << d), seg_tab[w[4*d +: 4]], 1'b1, (d == 3) ? SETTLE + SYNC_STAGES - 2 : 16);
      idle(2);
    end
    idle(12);
    n_vec++; if (obs_q.size() !== 0) begin n_err++; $display("[TB] FAIL short_no_frame: got %0d pulses expected 0", obs_q.size()); end
    scan_word(w, 16, 2);
    idle(12);
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL short_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL short_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (value !== w) begin n_err++; $display("[TB] FAIL short_value: got %h expected %h", value, w); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_blank_err();
    pulse_reset();
    drive_seg(8'b1111_1110, 7'h55, 1'b1, 16); idle(2);
    for (int d = 1; d < 6; d++) begin
      drive_seg(~(8'd1 << d), seg_tab[d], (d == 2) ? 1'b0 : 1'b1, 16); idle(2);
    end
    drive_seg(8'b1011_1111, 7'h7F, 1'b1, 16); idle(2);
    drive_seg(8'b0111_1111, 7'h7F, 1'b1, 16);
    idle(12);
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL blank_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL blank_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (blank_mask !== 8'hC0) begin n_err++; $display("[TB] FAIL blank_mask: got %h expected c0", blank_mask); end
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("[TB] FAIL blank_err: got %b expected 1", frame_err); end
    n_vec++; if (value !== 32'h00543210) begin n_err++; $display("[TB] FAIL blank_value: got %h expected 00543210", value); end
    n_vec++; if (dp_mask !== 8'h04) begin n_err++; $display("[TB] FAIL blank_dp: got %h expected 04", dp_mask); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_ghost();
    logic [31:0] w = 32'hA1B2C3D4;
    pulse_reset();
    for (int d = 0; d < 4; d++) begin drive_seg(~(8'd1 << d), seg_tab[w[4*d +: 4]], 1'b1, 16); idle(2); end
    drive_seg(8'b1111_0011, seg_tab[8], 1'b0, 20);
    idle(2);
    for (int d = 4; d < 8; d++) begin drive_seg(~(8'd1 << d), seg_tab[w[4*d +: 4]], 1'b1, 16); idle(2); end
    idle(12);
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL ghost_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL ghost_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if ({value, dp_mask} !== {w, 8'h00}) begin n_err++; $display("[TB] FAIL ghost_value: got %h/%h expected %h/00", value, dp_mask, w); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    for (int d = 0; d < 5; d++) begin drive_seg(~(8'd1 << d), seg_tab[4'(d + 9)], 1'b0, 16); idle(2); end
    rst = 1'b1;
    m_mask = 8'h00; m_err = 8'h00;
    @(negedge clk);
    n_vec++; if (value !== 32'h0) begin n_err++; $display("[TB] FAIL rstmid_value: got %h expected 0", value); end
    n_vec++; if ({dp_mask, blank_mask} !== 16'h0) begin n_err++; $display("[TB] FAIL rstmid_masks: got %h/%h expected 0/0", dp_mask, blank_mask); end
    n_vec++; if ({frame_valid, frame_err} !== 2'b00) begin n_err++; $display("[TB] FAIL rstmid_flags: got %b%b expected 00", frame_valid, frame_err); end
    @(posedge clk);
    #1 rst = 1'b0;
    scan_word(32'hF0F0A5C3, 16, 2);
    idle(12);
    n_vec++; if (obs_q.size() !== 1) begin n_err++; $display("[TB] FAIL rstmid_pulses: got %0d expected 1", obs_q.size()); end
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL rstmid_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL rstmid_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (value !== 32'hF0F0A5C3) begin n_err++; $display("[TB] FAIL rstmid_value2: got %h expected f0f0a5c3", value); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_order();
    int p[8];
    int r_pos, r, j, t;
    logic [31:0] w, exp_w;
    pulse_reset();
    for (int d = 7; d >= 0; d--) begin drive_seg(~(8'd1 << d), seg_tab[4'(d + 8)], 1'b1, 12); idle(1); end
    for (int i = 0; i < 8; i++) p[i] = i;
    for (int i = 7; i > 0; i--) begin j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t; end
    r_pos = $urandom_range(0, 3);
    r = p[r_pos];
    w = $urandom;
    exp_w = w;
    exp_w[4*r +: 4] = 4'h9;
    for (int i = 0; i < 7; i++) begin
      drive_seg(~(8'd1 << p[i]), seg_tab[(i == r_pos) ? 4'h4 : w[4*p[i] +: 4]], 1'b1, $urandom_range(6, 16));
      idle($urandom_range(0, 2));
    end
    drive_seg(~(8'd1 << r), seg_tab[9], 1'b1, $urandom_range(6, 16));
    idle($urandom_range(0, 2));
    drive_seg(~(8'd1 << p[7]), seg_tab[w[4*p[7] +: 4]], 1'b1, $urandom_range(6, 16));
    idle(12);
    n_vec++; if (obs_q.size() !== 2) begin n_err++; $display("[TB] FAIL order_pulses: got %0d expected 2", obs_q.size()); end
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL order_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL order_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (value !== exp_w) begin n_err++; $display("[TB] FAIL order_repeat: got %h expected %h (slot %0d)", value, exp_w, r); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] an, prev_an;
    logic [6:0] c;
    int kind, d, b1, b2;
    pulse_reset();
    prev_an = 8'hFF;
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 7);
      if (kind < 6) begin
        d = $urandom_range(0, 7);
        an = ~(8'd1 << d);
        if (an == prev_an) an = ~(8'd1 << ((d + 1) % 8));
      end else if (kind == 6) begin
        an = 8'hFF;
      end else begin
        b1 = $urandom_range(0, 7);
        b2 = (b1 + $urandom_range(1, 7)) % 8;
        an = ~((8'd1 << b1) | (8'd1 << b2));
      end
      c = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
      drive_seg(an, c, 1'($urandom), $urandom_range(1, 12));
      prev_an = an;
    end
    idle(12);
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL random_frame%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    m_mask = 8'h00; m_err = 8'h00; m_dp = 8'h00; m_blank = 8'h00;
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_blank_err();
    test_ghost();
    test_reset_midframe();
    test_order();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
